// File: rtl/alu_issue.sv
// Issue/operand stage ahead of the single-cycle ALU: regfile read, ALU-result and
// writeback forwarding, and a load scoreboard that holds back load-use hazards.
module alu_issue #(
    parameter int XLEN = 32,
    parameter int RA   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA-1:0]   in_rs1,
    input  logic [RA-1:0]   in_rs2,
    input  logic [RA-1:0]   in_rd,
    input  logic            in_wr,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_imm,

    output logic [RA-1:0]   rf_raddr1,
    output logic [RA-1:0]   rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,

    input  logic            wb_we,
    input  logic [RA-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] alu_rslt,

    input  logic            ld_set,
    input  logic [RA-1:0]   ld_rd,
    input  logic            ld_clr,
    input  logic [RA-1:0]   ld_clr_rd,

    input  logic            flush,
    input  logic            out_stall,

    output logic            out_valid,
    output logic [RA-1:0]   out_rd,
    output logic            out_wr,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] opd1,
    output logic [XLEN-1:0] opd2
);

    localparam int NREG = 1 << RA;

    typedef struct packed {
        logic            fwd;
        logic [XLEN-1:0] val;
    } src_t;

    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic [XLEN-1:0] opd1_q;
    logic [XLEN-1:0] opd2_q;
    logic            fwd1;
    logic            fwd2;

    logic            pend1;
    logic            pend2;
    logic            hazard;
    logic            accept;
    logic            alu_fwd_ok;
    src_t            src1;
    src_t            src2;

    // Operand source priority: x0, in-flight ALU op (forwarded next cycle), writeback port, regfile.
    function automatic src_t resolve(
        input logic [RA-1:0]   rs,
        input logic [XLEN-1:0] rdata,
        input logic            alu_ok,
        input logic [RA-1:0]   alu_rd,
        input logic            wb_ok,
        input logic [RA-1:0]   wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        src_t s;
        s.fwd = 1'b0;
        s.val = rdata;
        if (rs == '0) begin
            s.val = '0;
        end else if (alu_ok && alu_rd == rs) begin
            s.fwd = 1'b1;
            s.val = '0;
        end else if (wb_ok && wb_idx == rs) begin
            s.val = wb_val;
        end
        return s;
    endfunction

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // A load whose data is on the writeback port this cycle no longer blocks its readers.
    assign pend1 = (in_rs1 != '0) && sb[in_rs1] && !(ld_clr && ld_clr_rd == in_rs1);
    assign pend2 = (in_rs2 != '0) && sb[in_rs2] && !(ld_clr && ld_clr_rd == in_rs2);

    assign hazard   = in_valid && (pend1 || (!in_use_imm && pend2));
    assign in_ready = !out_stall && !flush && !hazard;
    assign accept   = in_valid && in_ready;

    assign alu_fwd_ok = out_valid && out_wr;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        src1 = resolve(in_rs1, rf_rdata1, alu_fwd_ok, out_rd, wb_we, wb_rd, wb_data);
        src2 = resolve(in_rs2, rf_rdata2, alu_fwd_ok, out_rd, wb_we, wb_rd, wb_data);
        if (in_use_imm) begin
            src2.fwd = 1'b0;
            src2.val = in_imm;
        end
    end

    always_comb begin
        sb_next = sb;
        if (ld_clr) begin
            sb_next[ld_clr_rd] = 1'b0;
        end
        if (ld_set && ld_rd != '0) begin
            sb_next[ld_rd] = 1'b1;
        end
    end

    assign opd1 = fwd1 ? alu_rslt : opd1_q;
    assign opd2 = fwd2 ? alu_rslt : opd2_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the scoreboard is a flop vector, not RAM, so it is cleared with the rest of the state.
            sb        <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
            funct3    <= '0;
            funct7    <= '0;
            opd1_q    <= '0;
            opd2_q    <= '0;
            fwd1      <= 1'b0;
            fwd2      <= 1'b0;
        end else begin
            sb <= sb_next;
            if (flush) begin
                out_valid <= 1'b0;
                fwd1      <= 1'b0;
                fwd2      <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_rd    <= in_rd;
                out_wr    <= in_wr && (in_rd != '0);
                funct3    <= in_funct3;
                funct7    <= in_funct7;
                opd1_q    <= src1.val;
                opd2_q    <= src2.val;
                fwd1      <= src1.fwd;
                fwd2      <= src2.fwd;
            end else begin
                // The producer's result is only on alu_rslt for one cycle; capture it before it moves on.
                if (fwd1) begin
                    opd1_q <= alu_rslt;
                    fwd1   <= 1'b0;
                end
                if (fwd2) begin
                    opd2_q <= alu_rslt;
                    fwd2   <= 1'b0;
                end
                if (!out_stall) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Loads never travel through this stage, so a load and an accepted ALU op cannot share a destination.
    ld_vs_alu_rd : assert property (@(posedge clk) disable iff (!rst)
        !(ld_set && accept && in_wr && in_rd != '0 && in_rd == ld_rd));

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios, then random traffic checked against an
// architectural register model with a small ALU/regfile/load environment around the DUT.
module tb_alu_issue;

    localparam int XLEN = 32;
    localparam int RA   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [RA-1:0]   in_rs1, in_rs2, in_rd;
    logic            in_wr;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic            in_use_imm;
    logic [XLEN-1:0] in_imm;
    logic [RA-1:0]   rf_raddr1, rf_raddr2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            wb_we;
    logic [RA-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] alu_rslt;
    logic            ld_set, ld_clr;
    logic [RA-1:0]   ld_rd, ld_clr_rd;
    logic            flush, out_stall;
    logic            out_valid, out_wr;
    logic [RA-1:0]   out_rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] opd1, opd2;

    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] alu_q;
    logic            alu_wb_v;
    logic [RA-1:0]   alu_wb_rd;
    logic            man_we;
    logic [RA-1:0]   man_rd;
    logic [XLEN-1:0] man_data;

    logic [XLEN-1:0] arch [32];
    int              infl [32];
    logic [2:0]      f3tab [4] = '{3'd0, 3'd4, 3'd6, 3'd7};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(XLEN), .RA(RA)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_rslt(alu_rslt),
        .ld_set(ld_set), .ld_rd(ld_rd), .ld_clr(ld_clr), .ld_clr_rd(ld_clr_rd),
        .flush(flush), .out_stall(out_stall),
        .out_valid(out_valid), .out_rd(out_rd), .out_wr(out_wr),
        .funct3(funct3), .funct7(funct7), .opd1(opd1), .opd2(opd2)
    );

    function automatic logic [XLEN-1:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f3)
            3'd0:    return f7[5] ? a - b : a + b;
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return a + b;
        endcase
    endfunction

    // Environment: regfile (x0 ignores writes), registered ALU, ALU writeback one cycle after retire.
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    assign wb_we     = alu_wb_v | man_we;
    assign wb_rd     = alu_wb_v ? alu_wb_rd : man_rd;
    assign wb_data   = alu_wb_v ? alu_q : man_data;
    assign alu_rslt  = alu_q;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            alu_q     <= '0;
            alu_wb_v  <= 1'b0;
            alu_wb_rd <= '0;
        end else begin
            if (wb_we && wb_rd != '0) rf[wb_rd] <= wb_data;
            alu_q     <= alu_fn(funct3, funct7, opd1, opd2);
            alu_wb_v  <= out_valid && out_wr && !out_stall && !flush;
            alu_wb_rd <= out_rd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_wr = 1'b0;
        in_funct3 = '0; in_funct7 = '0; in_use_imm = 1'b0; in_imm = '0;
        ld_set = 1'b0; ld_rd = '0; ld_clr = 1'b0; ld_clr_rd = '0;
        flush = 1'b0; out_stall = 1'b0;
        man_we = 1'b0; man_rd = '0; man_data = '0;
    endtask

    task automatic op(input int rs1, input int rs2, input int rd, input bit wr,
                      input int f3, input bit use_imm, input logic [XLEN-1:0] imm);
        in_valid = 1'b1; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_wr = wr;
        in_funct3 = 3'(f3); in_funct7 = '0; in_use_imm = use_imm; in_imm = imm;
    endtask

    task automatic drain();
        repeat (3) begin
            @(negedge clk);
            idle();
        end
    endtask

    task automatic wb_write(input int r, input logic [XLEN-1:0] v);
        @(negedge clk);
        idle();
        man_we = 1'b1; man_rd = 5'(r); man_data = v;
        @(negedge clk);
        idle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit              mv, lp, clr_now, acc, exp_ready, wb_alu;
        logic [RA-1:0]   lrd, wb_alu_rd, cand;
        logic [XLEN-1:0] lval, e_o1, e_o2, a, b;
        logic [15:0]     e_meta;
        logic [11:0]     r12;
        int              ldly;

        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_wr",    32'(out_wr), 0);
        check("rst_out_rd",    32'(out_rd), 0);
        check("rst_funct3",    32'(funct3), 0);
        check("rst_funct7",    32'(funct7), 0);
        check("rst_opd1",      opd1, 0);
        check("rst_opd2",      opd2, 0);
        check("rst_in_ready",  32'(in_ready), 1);
        rst = 1'b1;

        // Back-to-back forward: ADD x3=x1+x2 then ADDI x4=x3+5
        wb_write(1, 10);
        wb_write(2, 20);
        op(1, 2, 3, 1, 0, 0, 0);
        #1 check("b2b_ready_a", 32'(in_ready), 1);
        @(negedge clk);
        check("b2b_valid_a", 32'(out_valid), 1);
        check("b2b_opd1_a",  opd1, 10);
        check("b2b_opd2_a",  opd2, 20);
        op(3, 0, 4, 1, 0, 1, 5);
        #1 check("b2b_ready_b", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        check("b2b_valid_b", 32'(out_valid), 1);
        check("b2b_rd_b",    32'(out_rd), 4);
        check("b2b_opd1_b",  opd1, 30);
        check("b2b_opd2_b",  opd2, 5);
        @(negedge clk);
        check("b2b_alu_b",   alu_rslt, 35);
        drain();

        // Writeback bypass, and x0 never bypassed
        man_we = 1'b1; man_rd = 5'd7; man_data = 32'hDEAD;
        op(7, 0, 8, 1, 6, 0, 0);
        @(negedge clk);
        idle();
        check("wbbyp_opd1", opd1, 32'hDEAD);
        man_we = 1'b1; man_rd = 5'd0; man_data = 32'hBEEF;
        op(0, 0, 9, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        check("wbbyp_x0_opd1", opd1, 0);
        drain();

        // Load-use stall
        ld_set = 1'b1; ld_rd = 5'd9;
        @(negedge clk);
        idle();
        op(9, 0, 10, 1, 0, 0, 0);
        #1 check("ldu_stall1", 32'(in_ready), 0);
        @(negedge clk);
        #1 check("ldu_stall2", 32'(in_ready), 0);
        @(negedge clk);
        ld_clr = 1'b1; ld_clr_rd = 5'd9; man_we = 1'b1; man_rd = 5'd9; man_data = 32'h55;
        #1 check("ldu_clr_ready", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        check("ldu_valid", 32'(out_valid), 1);
        check("ldu_opd1",  opd1, 32'h55);
        op(9, 9, 11, 0, 0, 0, 0);
        #1 check("ldu_sb_cleared", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        check("ldu_rf_opd1", opd1, 32'h55);
        drain();

        // Flush with a concurrent load set
        op(1, 0, 11, 1, 0, 0, 0);
        @(negedge clk);
        check("fl_pre_valid", 32'(out_valid), 1);
        op(2, 0, 12, 1, 0, 0, 0);
        flush = 1'b1; ld_set = 1'b1; ld_rd = 5'd4;
        #1 check("fl_ready", 32'(in_ready), 0);
        @(negedge clk);
        idle();
        check("fl_valid", 32'(out_valid), 0);
        op(4, 0, 13, 0, 0, 0, 0);
        #1 check("fl_sb4_set", 32'(in_ready), 0);
        @(negedge clk);
        ld_clr = 1'b1; ld_clr_rd = 5'd4; man_we = 1'b1; man_rd = 5'd4; man_data = 32'h44;
        #1 check("fl_sb4_clr_ready", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        check("fl_ld_opd1", opd1, 32'h44);
        drain();

        // Forwarded operand held through a 3-cycle stall
        wb_write(1, 32'h1000);
        op(1, 0, 5, 1, 0, 1, 32'h234);
        @(negedge clk);
        op(5, 1, 6, 1, 0, 0, 0);
        #1 check("st_ready", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        check("st_fwd_opd1", opd1, 32'h1234);
        out_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("st_hold_valid", 32'(out_valid), 1);
            check("st_hold_opd1",  opd1, 32'h1234);
            check("st_hold_opd2",  opd2, 32'h1000);
            if (k == 0) check("st_alu_moved", alu_rslt, 32'h2234);
        end
        out_stall = 1'b0;
        @(negedge clk);
        check("st_release_valid", 32'(out_valid), 0);
        drain();

        // Asynchronous reset in the middle of an op with a pending load
        op(1, 0, 12, 1, 0, 0, 0);
        ld_set = 1'b1; ld_rd = 5'd5;
        @(negedge clk);
        idle();
        check("ar_pre_valid", 32'(out_valid), 1);
        op(5, 0, 13, 0, 0, 0, 0);
        #1 check("ar_pre_sb5", 32'(in_ready), 0);
        #1 rst = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_opd1",  opd1, 0);
        check("ar_sb_clear", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        rst = 1'b1;

        // Random traffic against the architectural model (state restarts from reset: all zero)
        for (int i = 0; i < 32; i++) begin
            arch[i] = '0;
            infl[i] = 0;
        end
        mv = 0; lp = 0; lrd = '0; lval = '0; ldly = 0;
        e_meta = '0; e_o1 = '0; e_o2 = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            check("rnd_valid", 32'(out_valid), 32'(mv));
            if (mv) begin
                check("rnd_meta", 32'({out_rd, out_wr, funct3, funct7}), 32'(e_meta));
                check("rnd_opd1", opd1, e_o1);
                check("rnd_opd2", opd2, e_o2);
            end
            wb_alu    = alu_wb_v;
            wb_alu_rd = alu_wb_rd;
            idle();
            clr_now = lp && ldly == 0 && !alu_wb_v;
            if (clr_now) begin
                ld_clr = 1'b1; ld_clr_rd = lrd; man_we = 1'b1; man_rd = lrd; man_data = lval;
            end
            if ($urandom_range(9) < 7) begin
                in_valid   = 1'b1;
                in_rs1     = 5'($urandom_range(7));
                in_rs2     = 5'($urandom_range(7));
                in_rd      = 5'($urandom_range(7));
                if (lp && in_rd == lrd) in_rd = '0;
                in_wr      = 1'($urandom_range(1));
                in_funct3  = f3tab[$urandom_range(3)];
                in_funct7  = (in_funct3 == 3'd0 && $urandom_range(1) == 1) ? 7'h20 : 7'h00;
                in_use_imm = 1'($urandom_range(1));
                r12        = 12'($urandom);
                in_imm     = {{20{r12[11]}}, r12};
            end
            out_stall = ($urandom_range(9) < 2);
            if (!lp && !clr_now && $urandom_range(9) < 2) begin
                cand = 5'($urandom_range(1, 7));
                if (infl[cand] == 0 && !(in_valid && in_wr && in_rd == cand)) begin
                    ld_set = 1'b1; ld_rd = cand;
                end
            end
            #1;
            exp_ready = !out_stall &&
                !(in_valid && ((in_rs1 != 0 && lp && lrd == in_rs1 && !clr_now) ||
                               (!in_use_imm && in_rs2 != 0 && lp && lrd == in_rs2 && !clr_now)));
            check("rnd_ready", 32'(in_ready), 32'(exp_ready));
            acc = in_valid && exp_ready;
            @(posedge clk);
            if (wb_alu) infl[wb_alu_rd]--;
            if (acc) begin
                a = (in_rs1 == 0) ? '0 : arch[in_rs1];
                b = in_use_imm ? in_imm : ((in_rs2 == 0) ? '0 : arch[in_rs2]);
                e_o1   = a;
                e_o2   = b;
                e_meta = {in_rd, in_wr && in_rd != 0, in_funct3, in_funct7};
                if (in_wr && in_rd != 0) begin
                    arch[in_rd] = alu_fn(in_funct3, in_funct7, a, b);
                    infl[in_rd]++;
                end
                mv = 1;
            end else if (!out_stall) begin
                mv = 0;
            end
            if (clr_now) lp = 0;
            else if (lp && ldly > 0) ldly--;
            if (ld_set) begin
                lp   = 1;
                lrd  = ld_rd;
                lval = $urandom;
                ldly = $urandom_range(3);
                arch[ld_rd] = lval;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue/operand stage directly upstream of the single-cycle-latency ALU. It accepts decoded R/I-type ops, reads the register file, and resolves operands by forwarding from the ALU result and the writeback port. A load scoreboard stalls ops that use a pending load destination. It drives funct3/funct7/opd1/opd2 so that a dependent op can issue back-to-back with no bubble.

Parameters:
XLEN, 32, datapath width
RA, 5, register index width (2**RA registers; x0 hardwired zero)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  decoded op present
in_ready  out  1  op accepted this cycle when in_valid&&in_ready
in_rs1, in_rs2  in  RA  source indices
in_rd  in  RA  destination index
in_wr  in  1  op writes rd
in_funct3  in  3  passed to ALU
in_funct7  in  7  passed to ALU
in_use_imm  in  1  opd2 = in_imm (I-type)
in_imm  in  XLEN  sign-extended immediate
rf_raddr1, rf_raddr2  out  RA  combinational = in_rs1/in_rs2
rf_rdata1, rf_rdata2  in  XLEN  combinational regfile read data
wb_we, wb_rd, wb_data  in  1/RA/XLEN  regfile write this cycle (ALU and load results)
alu_rslt  in  XLEN  ALU result (result of op presented the previous cycle)
ld_set, ld_rd  in  1/RA  load issued; mark ld_rd pending
ld_clr, ld_clr_rd  in  1/RA  load data on wb port this cycle; clear pending
flush  in  1  kill the held op
out_stall  in  1  downstream holds; keep outputs
out_valid, out_rd, out_wr  out  1/RA/1  issued op tag
funct3, funct7  out  3/7  to ALU
opd1, opd2  out  XLEN  to ALU

Behaviour:
- Reset (rst=0, async): out_valid=0, out_wr=0, out_rd=0, funct3=0, funct7=0, opd regs=0, fwd flags=0, scoreboard=0.
- pend(r) = sb[r] && !(ld_clr && ld_clr_rd==r). Read x0 is never pending.
- hazard = in_valid && (pend(in_rs1) || (!in_use_imm && pend(in_rs2))).
- in_ready = !out_stall && !flush && !hazard.
- Edge update:
  - flush: out_valid<=0 and fwd flags<=0.
  - else if out_stall: hold all outputs. For any set fwd flag, latch alu_rslt into that opd register and clear the flag on the first stall edge.
  - else: out_valid <= in_valid&&in_ready.
- On capture, the op fields are registered, with out_wr <= in_wr && in_rd!=0.
- Per-source resolution on capture, priority order (rsN = index, opd2 uses in_imm when in_use_imm):
  1. rsN==0 -> 0.
  2. out_valid && out_wr && out_rd==rsN -> set fwdN; output is alu_rslt next cycle (zero-bubble forward).
  3. wb_we && wb_rd==rsN -> wb_data.
  4. else rf_rdataN.
- opdN output = fwdN ? alu_rslt : opdN register (combinational mux).
- Scoreboard update at edge: set on ld_set (ld_rd!=0), clear on ld_clr. If both hit the same index, set wins. Updates proceed during stall and flush.
- When no op is accepted, outputs keep their last values with out_valid=0. The ALU may compute garbage, which the downstream stage ignores via the valid tag.
- Assertion, under the rule that ld_set only accompanies a load op: ld_set and a captured ALU op writing the same rd never occur in the same cycle.
- Latency: capture edge -> opd valid the following cycle; ALU result one cycle later.

Test Plan:
- Reset mid-operation: out_valid=1 and sb[5]=1, drop rst asynchronously -> out_valid=0, opd1=0, sb clear immediately without a clock edge.
- Back-to-back forward: issue ADD x3=x1+x2 (rf x1=10, x2=20), then ADDI x4=x3+5 next cycle -> second op issues without a bubble; opd1 shows alu_rslt=30, opd2=5; ALU result 35.
- Writeback bypass: wb_we=1, wb_rd=7, wb_data=0xDEAD while capturing an op with rs1=7 and rf_rdata1=0 -> opd1=0xDEAD. With rs1=0 and wb_rd=0 -> opd1=0.
- Load-use stall: ld_set rd=9, then op reading x9 -> in_ready=0 for two cycles. ld_clr=1, ld_clr_rd=9 with wb_data=0x55 -> same-cycle accept, opd1=0x55, sb[9] cleared.
- Stall with forward pending: forwarded op held by out_stall for 3 cycles while the producer's result is 0x1234 -> opd1 stays 0x1234 throughout; fwd flag cleared after the first stall edge.
- Flush: flush=1 with in_valid=1 -> in_ready=0; out_valid=0 next cycle; a concurrent ld_set rd=4 still sets sb[4].
